// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: FSM states and
// forwarding-mux select values.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_MEM_WAIT   = 2'b01,
        ST_FLUSH_PEND = 2'b10
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side signal bundle of the hazard/forwarding unit.
// master = pipeline (drives stage info), slave = hazard unit.
interface hazard_forward_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*REG_AW-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_valid;
    logic                      exe_wb_en;
    logic                      exe_mem_read;
    logic [REG_AW-1:0]         exe_dest;
    logic                      mem_wb_en;
    logic [REG_AW-1:0]         mem_dest;
    logic                      wb_wb_en;
    logic [REG_AW-1:0]         wb_dest;
    logic                      mem_busy;
    logic                      branch_taken;
    logic                      cnt_clr;
    logic                      freeze;
    logic                      flush;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic [CNT_W-1:0]          stall_count;
    logic [1:0]                state;

    modport master (
        output src_addr, src_valid, exe_wb_en, exe_mem_read, exe_dest,
               mem_wb_en, mem_dest, wb_wb_en, wb_dest, mem_busy,
               branch_taken, cnt_clr,
        input  freeze, flush, fwd_sel, stall_count, state
    );

    modport slave (
        input  src_addr, src_valid, exe_wb_en, exe_mem_read, exe_dest,
               mem_wb_en, mem_dest, wb_wb_en, wb_dest, mem_busy,
               branch_taken, cnt_clr,
        output freeze, flush, fwd_sel, stall_count, state
    );

endinterface

// File: rtl/hazard_src_cmp.sv
// Per-operand comparator: decides whether one ID-stage source operand
// needs a stall and where its value should be forwarded from.
module hazard_src_cmp
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter bit FWD_EN   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic              src_valid,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              wb_wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    output logic              hazard,
    output logic [1:0]        fwd_sel
);

    // A read of register d that a later stage is about to overwrite.
    // The hardwired zero register never depends on anything.
    function automatic logic match(input logic [REG_AW-1:0] a,
                                   input logic              v,
                                   input logic [REG_AW-1:0] d,
                                   input logic              en);
        return v & en & (a == d) & ~(ZERO_REG & (d == {REG_AW{1'b0}}));
    endfunction

    logic exe_m_s;
    logic exe_ld_m_s;
    logic mem_m_s;
    logic wb_m_s;

    // Hazard and forwarding select for this operand.
    always_comb begin
        exe_m_s    = match(src_addr, src_valid, exe_dest, exe_wb_en);
        exe_ld_m_s = match(src_addr, src_valid, exe_dest, exe_wb_en & exe_mem_read);
        mem_m_s    = match(src_addr, src_valid, mem_dest, mem_wb_en);
        wb_m_s     = match(src_addr, src_valid, wb_dest, wb_wb_en);
        hazard     = 1'b0;
        fwd_sel    = FWD_RF;
        if (FWD_EN) begin
            // Only a load in EXE cannot be bypassed in time.
            hazard = exe_ld_m_s;
            if (mem_m_s) begin
                fwd_sel = FWD_MEM;
            end else if (wb_m_s) begin
                fwd_sel = FWD_WB;
            end else begin
                fwd_sel = FWD_RF;
            end
        end else begin
            hazard  = exe_m_s | mem_m_s;
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit for the 5-stage pipeline: data-hazard freeze,
// branch flush (deferred across memory waits), forwarding selects and a
// saturating stall-cycle counter.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter bit FWD_EN   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_forward_unit_if.slave  bus
);

    logic [NUM_SRC-1:0]   hazard_vec_s;
    logic [2*NUM_SRC-1:0] fwd_sel_s;
    logic                 data_hazard_s;
    logic                 freeze_s;
    logic                 flush_s;
    state_e               state_r;
    state_e               state_nxt_s;
    logic                 pending_r;
    logic                 pending_nxt_s;
    logic [CNT_W-1:0]     stall_count_r;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_cmp #(
            .REG_AW   (REG_AW),
            .FWD_EN   (FWD_EN),
            .ZERO_REG (ZERO_REG)
        ) u_cmp (
            .src_addr     (bus.src_addr[i*REG_AW +: REG_AW]),
            .src_valid    (bus.src_valid[i]),
            .exe_wb_en    (bus.exe_wb_en),
            .exe_mem_read (bus.exe_mem_read),
            .exe_dest     (bus.exe_dest),
            .mem_wb_en    (bus.mem_wb_en),
            .mem_dest     (bus.mem_dest),
            .wb_wb_en     (bus.wb_wb_en),
            .wb_dest      (bus.wb_dest),
            .hazard       (hazard_vec_s[i]),
            .fwd_sel      (fwd_sel_s[2*i +: 2])
        );
    end

    // Pipeline control outputs; a squashed ID instruction never freezes,
    // and everything is quiet while reset is held.
    always_comb begin
        data_hazard_s = |hazard_vec_s;
        freeze_s      = 1'b0;
        flush_s       = 1'b0;
        bus.fwd_sel   = {(2*NUM_SRC){1'b0}};
        if (rst_n) begin
            freeze_s    = bus.mem_busy |
                          (data_hazard_s & ~bus.branch_taken & (state_r != ST_FLUSH_PEND));
            flush_s     = (bus.branch_taken & ~bus.mem_busy) | (state_r == ST_FLUSH_PEND);
            bus.fwd_sel = fwd_sel_s;
        end else begin
            freeze_s    = 1'b0;
            flush_s     = 1'b0;
            bus.fwd_sel = {(2*NUM_SRC){1'b0}};
        end
    end

    // Next state of the memory-wait FSM and the deferred-branch flag.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        case (state_r)
            ST_RUN: begin
                if (bus.mem_busy) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_busy) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else if (pending_r) begin
                    state_nxt_s = ST_FLUSH_PEND;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH_PEND: begin
                state_nxt_s   = ST_RUN;
                pending_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s   = ST_RUN;
                pending_nxt_s = 1'b0;
            end
        endcase
        // A branch that resolves while memory stalls is remembered so it
        // flushes exactly once after the stall; repeats are absorbed.
        if (bus.branch_taken & bus.mem_busy) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // FSM state and pending flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    // Saturating count of frozen cycles; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (bus.cnt_clr) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (freeze_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.freeze      = freeze_s;
    assign bus.flush       = flush_s;
    assign bus.stall_count = stall_count_r;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: a forwarding-mode and a stall-mode instance share the
// same stimulus; combinational vectors from a table, then hand-written
// multi-cycle sequences.
module tb_hazard_forward_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) if_f ();
    hazard_forward_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) if_s ();

    hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_EN(1'b1), .ZERO_REG(1'b1), .CNT_W(16))
        dut_f (.clk(clk), .rst_n(rst_n), .bus(if_f));
    hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_EN(1'b0), .ZERO_REG(1'b1), .CNT_W(16))
        dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

    assign if_s.src_addr     = if_f.src_addr;
    assign if_s.src_valid    = if_f.src_valid;
    assign if_s.exe_wb_en    = if_f.exe_wb_en;
    assign if_s.exe_mem_read = if_f.exe_mem_read;
    assign if_s.exe_dest     = if_f.exe_dest;
    assign if_s.mem_wb_en    = if_f.mem_wb_en;
    assign if_s.mem_dest     = if_f.mem_dest;
    assign if_s.wb_wb_en     = if_f.wb_wb_en;
    assign if_s.wb_dest      = if_f.wb_dest;
    assign if_s.mem_busy     = if_f.mem_busy;
    assign if_s.branch_taken = if_f.branch_taken;
    assign if_s.cnt_clr      = if_f.cnt_clr;

    typedef struct {
        logic [9:0] src_addr;
        logic [1:0] src_valid;
        logic       exe_wb_en;
        logic       exe_mem_read;
        logic [4:0] exe_dest;
        logic       mem_wb_en;
        logic [4:0] mem_dest;
        logic       wb_wb_en;
        logic [4:0] wb_dest;
        logic       branch_taken;
        logic       f_freeze;
        logic       f_flush;
        logic [3:0] f_fwd;
        logic       s_freeze;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_f.src_addr     = 10'd0;
        if_f.src_valid    = 2'b00;
        if_f.exe_wb_en    = 1'b0;
        if_f.exe_mem_read = 1'b0;
        if_f.exe_dest     = 5'd0;
        if_f.mem_wb_en    = 1'b0;
        if_f.mem_dest     = 5'd0;
        if_f.wb_wb_en     = 1'b0;
        if_f.wb_dest      = 5'd0;
        if_f.mem_busy     = 1'b0;
        if_f.branch_taken = 1'b0;
        if_f.cnt_clr      = 1'b0;
    endtask

    logic       seq_busy [6];
    logic       seq_br   [6];
    logic       seq_fz   [6];
    logic       seq_fl   [6];
    logic [1:0] seq_st   [6];

    initial begin
        //        src_addr      valid  exw  exr  exd   mw   md    ww   wd    br    ffz  ffl  ffwd     sfz
        vecs[0]  = '{{5'd0,5'd0}, 2'b00, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 1'b0,1'b0,4'b0000, 1'b0};
        vecs[1]  = '{{5'd0,5'd3}, 2'b01, 1'b1,1'b1,5'd3, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 1'b1,1'b0,4'b0000, 1'b1};
        vecs[2]  = '{{5'd0,5'd3}, 2'b01, 1'b1,1'b0,5'd3, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 1'b0,1'b0,4'b0000, 1'b1};
        vecs[3]  = '{{5'd7,5'd0}, 2'b10, 1'b0,1'b0,5'd0, 1'b1,5'd7, 1'b1,5'd7, 1'b0, 1'b0,1'b0,4'b0100, 1'b1};
        vecs[4]  = '{{5'd0,5'd0}, 2'b10, 1'b0,1'b0,5'd0, 1'b1,5'd7, 1'b1,5'd7, 1'b0, 1'b0,1'b0,4'b0000, 1'b0};
        vecs[5]  = '{{5'd0,5'd0}, 2'b11, 1'b0,1'b0,5'd0, 1'b1,5'd0, 1'b1,5'd0, 1'b0, 1'b0,1'b0,4'b0000, 1'b0};
        vecs[6]  = '{{5'd0,5'd4}, 2'b01, 1'b0,1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd4, 1'b0, 1'b0,1'b0,4'b0010, 1'b0};
        vecs[7]  = '{{5'd5,5'd0}, 2'b00, 1'b1,1'b0,5'd5, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 1'b0,1'b0,4'b0000, 1'b0};
        vecs[8]  = '{{5'd5,5'd0}, 2'b10, 1'b1,1'b0,5'd5, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 1'b0,1'b0,4'b0000, 1'b1};
        vecs[9]  = '{{5'd6,5'd2}, 2'b11, 1'b0,1'b0,5'd0, 1'b1,5'd2, 1'b1,5'd6, 1'b0, 1'b0,1'b0,4'b1001, 1'b1};
        vecs[10] = '{{5'd0,5'd3}, 2'b01, 1'b1,1'b1,5'd3, 1'b0,5'd0, 1'b0,5'd0, 1'b1, 1'b0,1'b1,4'b0000, 1'b0};
        vecs[11] = '{{5'd0,5'd7}, 2'b01, 1'b0,1'b0,5'd0, 1'b0,5'd7, 1'b0,5'd0, 1'b0, 1'b0,1'b0,4'b0000, 1'b0};
        vecs[12] = '{{5'd0,5'd0}, 2'b01, 1'b1,1'b1,5'd0, 1'b0,5'd0, 1'b0,5'd0, 1'b0, 1'b0,1'b0,4'b0000, 1'b0};
        vecs[13] = '{{5'd9,5'd0}, 2'b10, 1'b1,1'b1,5'd9, 1'b1,5'd9, 1'b0,5'd0, 1'b0, 1'b1,1'b0,4'b0100, 1'b1};
        vecs[14] = '{{5'd0,5'd8}, 2'b01, 1'b0,1'b0,5'd0, 1'b0,5'd8, 1'b1,5'd8, 1'b0, 1'b0,1'b0,4'b0010, 1'b0};

        // Reset: inputs that would otherwise freeze, flush and forward.
        clear_inputs();
        if_f.mem_busy     = 1'b1;
        if_f.branch_taken = 1'b1;
        if_f.mem_wb_en    = 1'b1;
        if_f.mem_dest     = 5'd3;
        if_f.src_addr     = {5'd0, 5'd3};
        if_f.src_valid    = 2'b01;
        #3;
        chk("rst_freeze", {31'd0, if_f.freeze}, 32'd0);
        chk("rst_flush", {31'd0, if_f.flush}, 32'd0);
        chk("rst_fwd", {28'd0, if_f.fwd_sel}, 32'd0);
        chk("rst_state", {30'd0, if_f.state}, 32'd0);
        chk("rst_count", {16'd0, if_f.stall_count}, 32'd0);
        chk("rst_s_freeze", {31'd0, if_s.freeze}, 32'd0);
        clear_inputs();
        #9 rst_n = 1'b1;
        tick();

        // Single-cycle combinational vectors in RUN.
        for (int i = 0; i < 15; i++) begin
            if_f.src_addr     = vecs[i].src_addr;
            if_f.src_valid    = vecs[i].src_valid;
            if_f.exe_wb_en    = vecs[i].exe_wb_en;
            if_f.exe_mem_read = vecs[i].exe_mem_read;
            if_f.exe_dest     = vecs[i].exe_dest;
            if_f.mem_wb_en    = vecs[i].mem_wb_en;
            if_f.mem_dest     = vecs[i].mem_dest;
            if_f.wb_wb_en     = vecs[i].wb_wb_en;
            if_f.wb_dest      = vecs[i].wb_dest;
            if_f.branch_taken = vecs[i].branch_taken;
            #1;
            chk($sformatf("vec%0d_f_freeze", i), {31'd0, if_f.freeze}, {31'd0, vecs[i].f_freeze});
            chk($sformatf("vec%0d_f_flush", i), {31'd0, if_f.flush}, {31'd0, vecs[i].f_flush});
            chk($sformatf("vec%0d_f_fwd", i), {28'd0, if_f.fwd_sel}, {28'd0, vecs[i].f_fwd});
            chk($sformatf("vec%0d_s_freeze", i), {31'd0, if_s.freeze}, {31'd0, vecs[i].s_freeze});
            chk($sformatf("vec%0d_s_flush", i), {31'd0, if_s.flush}, {31'd0, vecs[i].f_flush});
            chk($sformatf("vec%0d_s_fwd", i), {28'd0, if_s.fwd_sel}, 32'd0);
            tick();
            chk($sformatf("vec%0d_state", i), {30'd0, if_f.state}, 32'd0);
        end
        clear_inputs();
        tick();

        // Load-use: one freeze cycle, then forward from MEM.
        if_f.src_addr     = {5'd0, 5'd3};
        if_f.src_valid    = 2'b01;
        if_f.exe_wb_en    = 1'b1;
        if_f.exe_mem_read = 1'b1;
        if_f.exe_dest     = 5'd3;
        #1;
        chk("lu_c1_freeze", {31'd0, if_f.freeze}, 32'd1);
        tick();
        if_f.exe_wb_en    = 1'b0;
        if_f.exe_mem_read = 1'b0;
        if_f.exe_dest     = 5'd0;
        if_f.mem_wb_en    = 1'b1;
        if_f.mem_dest     = 5'd3;
        #1;
        chk("lu_c2_freeze", {31'd0, if_f.freeze}, 32'd0);
        chk("lu_c2_fwd", {28'd0, if_f.fwd_sel}, 32'd1);
        chk("lu_c2_s_freeze", {31'd0, if_s.freeze}, 32'd1);
        tick();
        clear_inputs();
        tick();

        // Branch during a 4-cycle memory stall.
        seq_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        seq_br   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_fz   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        seq_fl   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        seq_st   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
        for (int c = 0; c < 6; c++) begin
            if_f.mem_busy     = seq_busy[c];
            if_f.branch_taken = seq_br[c];
            #1;
            chk($sformatf("mw_c%0d_freeze", c), {31'd0, if_f.freeze}, {31'd0, seq_fz[c]});
            chk($sformatf("mw_c%0d_flush", c), {31'd0, if_f.flush}, {31'd0, seq_fl[c]});
            tick();
            chk($sformatf("mw_c%0d_state", c), {30'd0, if_f.state}, {30'd0, seq_st[c]});
        end
        clear_inputs();

        // Branch repeated while pending: a single flush.
        seq_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        seq_br   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        seq_fl   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        seq_st   = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
        for (int c = 0; c < 6; c++) begin
            if_f.mem_busy     = seq_busy[c];
            if_f.branch_taken = seq_br[c];
            #1;
            chk($sformatf("rb_c%0d_flush", c), {31'd0, if_f.flush}, {31'd0, seq_fl[c]});
            tick();
            chk($sformatf("rb_c%0d_state", c), {30'd0, if_f.state}, {30'd0, seq_st[c]});
        end
        clear_inputs();

        // Counter saturation, then clear with priority over increment.
        if_f.cnt_clr = 1'b1;
        tick();
        chk("cnt_clr0", {16'd0, if_f.stall_count}, 32'd0);
        if_f.cnt_clr  = 1'b0;
        if_f.mem_busy = 1'b1;
        repeat (65539) tick();
        chk("cnt_sat_f", {16'd0, if_f.stall_count}, 32'h0000_FFFF);
        chk("cnt_sat_s", {16'd0, if_s.stall_count}, 32'h0000_FFFF);
        if_f.cnt_clr = 1'b1;
        tick();
        chk("cnt_clr_busy", {16'd0, if_f.stall_count}, 32'd0);
        clear_inputs();
        tick();
        chk("cnt_back_run", {30'd0, if_f.state}, 32'd0);

        // Reset in MEM_WAIT with a pending branch drops the flush.
        if_f.mem_busy     = 1'b1;
        if_f.branch_taken = 1'b1;
        tick();
        if_f.branch_taken = 1'b0;
        tick();
        chk("rs_pre_state", {30'd0, if_f.state}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_state", {30'd0, if_f.state}, 32'd0);
        chk("rs_freeze", {31'd0, if_f.freeze}, 32'd0);
        chk("rs_count", {16'd0, if_f.stall_count}, 32'd0);
        if_f.mem_busy = 1'b0;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rs_c%0d_flush", c), {31'd0, if_f.flush}, 32'd0);
            tick();
            chk($sformatf("rs_c%0d_state", c), {30'd0, if_f.state}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
